// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control encodings, FSM states and multi-cycle helper
package alu_ctrl_pkg;

  typedef logic [3:0] ctrl_t;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_RTYPE = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SLE   = 4'd8;
  localparam logic [3:0] OP_SLL   = 4'd9;
  localparam logic [3:0] OP_SRL   = 4'd10;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_MUL = 6'h02;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_DIV = 6'h1A;
  localparam logic [5:0] F_SRA = 6'h03;

  localparam ctrl_t C_AND = 4'd0;
  localparam ctrl_t C_OR  = 4'd1;
  localparam ctrl_t C_ADD = 4'd2;
  localparam ctrl_t C_MUL = 4'd3;
  localparam ctrl_t C_XOR = 4'd4;
  localparam ctrl_t C_SLL = 4'd5;
  localparam ctrl_t C_SUB = 4'd6;
  localparam ctrl_t C_SLT = 4'd7;
  localparam ctrl_t C_SRL = 4'd8;
  localparam ctrl_t C_SLE = 4'd9;
  localparam ctrl_t C_DIV = 4'd10;
  localparam ctrl_t C_SRA = 4'd11;
  localparam ctrl_t C_NOR = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

  function automatic logic is_multi(input ctrl_t code);
    return (code == C_MUL) || (code == C_DIV);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp/Funct to ALUControl decoder
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int EXT_OPS = 1
) (
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [5:0]         Funct,
  output ctrl_t              code,
  output logic               illegal
);

  always_comb begin
    code    = C_AND;
    illegal = 1'b0;
    case (ALUOp)
      ALUOP_W'(OP_ADD): code = C_ADD;
      ALUOP_W'(OP_SUB): code = C_SUB;
      ALUOP_W'(OP_MUL): code = C_MUL;
      ALUOP_W'(OP_AND): code = C_AND;
      ALUOP_W'(OP_OR):  code = C_OR;
      ALUOP_W'(OP_XOR): code = C_XOR;
      ALUOP_W'(OP_SLT): code = C_SLT;
      ALUOP_W'(OP_SLE): code = C_SLE;
      ALUOP_W'(OP_SLL): code = C_SLL;
      ALUOP_W'(OP_SRL): code = C_SRL;
      ALUOP_W'(OP_RTYPE): begin
        case (Funct)
          F_ADD: code = C_ADD;
          F_MUL: code = C_MUL;
          F_AND: code = C_AND;
          F_OR:  code = C_OR;
          F_XOR: code = C_XOR;
          F_SLL: code = C_SLL;
          F_SUB: code = C_SUB;
          F_SLT: code = C_SLT;
          F_NOR: code = C_NOR;
          F_DIV: begin
            code    = (EXT_OPS != 0) ? C_DIV : C_AND;
            illegal = (EXT_OPS == 0);
          end
          F_SRA: begin
            code    = (EXT_OPS != 0) ? C_SRA : C_AND;
            illegal = (EXT_OPS == 0);
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered ALU control with multi-cycle hold and valid/ready handshake
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 4,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 8,
  parameter int EXT_OPS    = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [5:0]         Funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ALUControl,
  output logic               illegal,
  output logic               busy
);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  ctrl_t      code_q, code_n;
  logic       ill_q, ill_n;
  ctrl_t      dec_code;
  logic       dec_ill;
  logic       load;
  logic       go_busy;
  logic [3:0] load_cnt;

  alu_ctrl_decode #(.ALUOP_W(ALUOP_W), .EXT_OPS(EXT_OPS)) u_decode (
    .ALUOp   (ALUOp),
    .Funct   (Funct),
    .code    (dec_code),
    .illegal (dec_ill)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      code_q <= C_AND;
      ill_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      code_q <= code_n;
      ill_q  <= ill_n;
    end
  end

  // A one-cycle multi op behaves exactly like a single-cycle op.
  always_comb begin
    go_busy  = 1'b0;
    load_cnt = 4'd0;
    if (!dec_ill && is_multi(dec_code)) begin
      if (dec_code == C_MUL) begin
        go_busy  = (MUL_CYCLES > 1);
        load_cnt = 4'(MUL_CYCLES - 2);
      end else begin
        go_busy  = (DIV_CYCLES > 1);
        load_cnt = 4'(DIV_CYCLES - 2);
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    code_n   = code_q;
    ill_n    = ill_q;
    in_ready = Rst && !flush && ((state == S_IDLE) || ((state == S_HOLD) && out_ready));
    load     = in_valid && in_ready;
    if (flush) begin
      state_n = S_IDLE;
      cnt_n   = 4'd0;
      code_n  = C_AND;
      ill_n   = 1'b0;
    end else begin
      case (state)
        S_BUSY: begin
          if (cnt == 4'd0) state_n = S_HOLD;
          else             cnt_n   = cnt - 4'd1;
        end
        default: begin
          if (load) begin
            code_n  = dec_code;
            ill_n   = dec_ill;
            state_n = go_busy ? S_BUSY : S_HOLD;
            cnt_n   = go_busy ? load_cnt : 4'd0;
          end else if ((state == S_HOLD) && out_ready) begin
            state_n = S_IDLE;
          end
        end
      endcase
    end
  end

  assign out_valid  = (state == S_HOLD);
  assign busy       = (state == S_BUSY);
  assign illegal    = ill_q;
  assign ALUControl = CTRL_W'(code_q);

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - directed self-checking bench for alu_control_seq
module tb_alu_control_seq;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       flush;
  logic       in_valid;
  logic [3:0] ALUOp;
  logic [5:0] Funct;
  logic       out_ready;

  logic       in_ready, out_valid, illegal, busy;
  logic [3:0] ALUControl;
  logic       in_ready_b, out_valid_b, illegal_b, busy_b;
  logic [3:0] ALUControl_b;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  alu_control_seq #(.ALUOP_W(4), .CTRL_W(4), .MUL_CYCLES(3), .DIV_CYCLES(8), .EXT_OPS(1)) dut (
    .Clk(Clk), .Rst(Rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct(Funct), .out_valid(out_valid), .out_ready(out_ready),
    .ALUControl(ALUControl), .illegal(illegal), .busy(busy)
  );

  alu_control_seq #(.ALUOP_W(4), .CTRL_W(4), .MUL_CYCLES(3), .DIV_CYCLES(8), .EXT_OPS(0)) dut_noext (
    .Clk(Clk), .Rst(Rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .ALUOp(ALUOp), .Funct(Funct), .out_valid(out_valid_b), .out_ready(out_ready),
    .ALUControl(ALUControl_b), .illegal(illegal_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [5:0] fn);
    ALUOp = op; Funct = fn; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  typedef struct { logic [3:0] op; logic [5:0] fn; logic [3:0] code; logic ill; } vec_t;
  vec_t vecs[7] = '{
    '{4'd2,  6'h27, 4'd12, 1'b0},
    '{4'd2,  6'h03, 4'd11, 1'b0},
    '{4'd2,  6'h2A, 4'd7,  1'b0},
    '{4'd8,  6'h00, 4'd9,  1'b0},
    '{4'd9,  6'h00, 4'd5,  1'b0},
    '{4'd2,  6'h3F, 4'd0,  1'b1},
    '{4'd13, 6'h00, 4'd0,  1'b1}
  };

  initial begin
    Rst = 1'b0; flush = 1'b0; in_valid = 1'b0; ALUOp = '0; Funct = '0; out_ready = 1'b1;
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_ctrl", ALUControl, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    Rst = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);

    // single-cycle add via funct
    issue(4'd2, 6'h20);
    check("add_valid", out_valid, 1);
    check("add_ctrl", ALUControl, 2);
    check("add_ill", illegal, 0);
    check("add_busy", busy, 0);
    tick();
    check("add_idle", out_valid, 0);

    // mul: two busy cycles, valid in the third
    issue(4'd2, 6'h02);
    for (int i = 0; i < 2; i++) begin
      check("mul_busy", busy, 1);
      check("mul_in_ready", in_ready, 0);
      check("mul_nvalid", out_valid, 0);
      check("mul_ctrl_hold", ALUControl, 3);
      tick();
    end
    check("mul_valid", out_valid, 1);
    check("mul_ctrl", ALUControl, 3);
    check("mul_busy_end", busy, 0);
    tick();

    // back-to-back ADD, SUB, AND
    ALUOp = 4'd0; in_valid = 1'b1; tick();
    check("b2b0_valid", out_valid, 1);
    check("b2b0_ctrl", ALUControl, 2);
    check("b2b0_ready", in_ready, 1);
    ALUOp = 4'd1; tick();
    check("b2b1_valid", out_valid, 1);
    check("b2b1_ctrl", ALUControl, 6);
    ALUOp = 4'd4; tick();
    check("b2b2_valid", out_valid, 1);
    check("b2b2_ctrl", ALUControl, 0);
    in_valid = 1'b0; tick();
    check("b2b_drain", out_valid, 0);

    // same sequence with a two-cycle stall on the first op
    out_ready = 1'b0;
    ALUOp = 4'd0; in_valid = 1'b1; tick();
    ALUOp = 4'd1;
    for (int i = 0; i < 2; i++) begin
      check("stall_ctrl", ALUControl, 2);
      check("stall_valid", out_valid, 1);
      check("stall_ready", in_ready, 0);
      if (i == 0) tick();
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", in_ready, 1);
    tick();
    check("stall_op1", ALUControl, 6);
    ALUOp = 4'd4; tick();
    check("stall_op2", ALUControl, 0);
    in_valid = 1'b0; tick();
    check("stall_drain", out_valid, 0);

    // div: 8-cycle latency with ext ops, illegal single-cycle without
    issue(4'd2, 6'h1A);
    check("noext_valid", out_valid_b, 1);
    check("noext_ctrl", ALUControl_b, 0);
    check("noext_ill", illegal_b, 1);
    check("div_busy", busy, 1);
    for (int i = 2; i <= 7; i++) begin
      tick();
      check("div_nvalid", out_valid, 0);
    end
    tick();
    check("div_valid", out_valid, 1);
    check("div_ctrl", ALUControl, 10);
    check("div_ill", illegal, 0);
    tick();

    // decode table of single-cycle cases
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].op, vecs[i].fn);
      check("vec_valid", out_valid, 1);
      check("vec_ctrl", ALUControl, vecs[i].code);
      check("vec_ill", illegal, vecs[i].ill);
      check("vec_busy", busy, 0);
      tick();
    end

    // flush in the second busy cycle drops the concurrent input
    issue(4'd3, 6'h00);
    tick();
    check("fl_busy2", busy, 1);
    flush = 1'b1; ALUOp = 4'd0; in_valid = 1'b1;
    #1;
    check("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_busy", busy, 0);
    check("fl_ctrl", ALUControl, 0);
    tick();
    check("fl_dropped", out_valid, 0);

    // asynchronous reset mid-busy
    issue(4'd3, 6'h00);
    check("ar_busy", busy, 1);
    #2 Rst = 1'b0;
    #1;
    check("ar_busy0", busy, 0);
    check("ar_ctrl0", ALUControl, 0);
    check("ar_valid0", out_valid, 0);
    check("ar_ready0", in_ready, 0);
    tick();
    Rst = 1'b1;
    issue(4'd10, 6'h00);
    check("ar_srl_valid", out_valid, 1);
    check("ar_srl_ctrl", ALUControl, 8);
    check("ar_srl_ill", illegal, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Registered, handshaked successor of the combinational ALU control decoder.
- Decodes ALUOp plus the R-type funct field into an ALUControl code.
- Holds the code stable for multi-cycle operations (mul, optional div), then presents it with valid/ready flow control to the execute stage.
- Sits between the ID/EX pipeline register and the ALU. It provides the stall source for multi-cycle ALU ops.

Parameters:
- ALUOP_W, 4, width of ALUOp input
- CTRL_W, 4, width of ALUControl output
- MUL_CYCLES, 3, cycles from acceptance to out_valid for ALUControl=3 (mul); legal range 1..15
- DIV_CYCLES, 8, cycles from acceptance to out_valid for ALUControl=10 (div); legal range 1..15
- EXT_OPS, 1, 1 enables extended funct decode (div, sra); 0 decodes those as illegal

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  ALUOp/Funct valid
- in_ready  out  1  block can accept
- ALUOp  in  ALUOP_W  main-control ALU operation class
- Funct  in  6  Instruction[5:0]
- out_valid  out  1  ALUControl valid for the ALU
- out_ready  in  1  execute stage consumes
- ALUControl  out  CTRL_W  registered ALU operation code
- illegal  out  1  held op was an undecodable ALUOp/funct; qualified by out_valid
- busy  out  1  multi-cycle op in progress; stall to upstream

Behaviour:
- ALUOp decode: 0→2, 1→6, 2→funct, 3→3, 4→0, 5→1, 6→4, 7→7, 8→9, 9→5, 10→8. Other ALUOp values give 0 and set illegal.
- Funct decode (ALUOp=2): 0x20→2, 0x02→3, 0x24→0, 0x25→1, 0x26→4, 0x00→5, 0x22→6, 0x2A→7, 0x27→12.
- Extended funct decode (EXT_OPS=1 only): 0x1A→10 (div), 0x03→11 (sra). Any other funct gives 0 and sets illegal.
- States: IDLE, BUSY, HOLD.
- Acceptance occurs on a rising edge with in_valid && in_ready. The decoded code and illegal flag are latched and held until consumed.
- in_ready = Rst && !flush && (state==IDLE || (state==HOLD && out_ready)). This allows back-to-back single-cycle ops at one per cycle.
- Single-cycle op (any code except 3 and 10): next state is HOLD; out_valid=1 on the cycle after acceptance (latency 1).
- Multi-cycle op (code 3, or code 10 with EXT_OPS=1):
  - If its CYCLES parameter equals 1, it is treated as single-cycle.
  - Otherwise: next state is BUSY and the counter loads CYCLES-2.
  - BUSY decrements each cycle; on reaching 0 it goes to HOLD. out_valid therefore rises exactly CYCLES cycles after the acceptance edge.
  - busy=1 only in BUSY. ALUControl is stable throughout BUSY and HOLD.
- HOLD:
  - out_valid=1.
  - On out_ready: go to IDLE, or load the next accepted op (BUSY or HOLD per decode).
  - Without out_ready: stay, with all outputs stable.
- flush is the highest synchronous priority: next state IDLE; ALUControl, illegal, busy, out_valid and the counter cleared to 0. in_ready=0 in the flush cycle, so any concurrent input is dropped. A flush in BUSY aborts the count.
- Reset (Rst=0, asynchronous, at any time including mid-BUSY): state IDLE; counter 0; ALUControl=0, out_valid=0, illegal=0, busy=0, in_ready=0. in_ready rises combinationally after Rst deasserts.
- Illegal ops follow single-cycle timing and are never multi-cycle.
- Counter width is 4 bits. ALUControl is zero-extended when CTRL_W>4.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALUOp class constants (0..10)
  - funct constants
  - ALUControl code constants (AND=0, OR=1, ADD=2, MUL=3, XOR=4, SLL=5, SUB=6, SLT=7, SRL=8, SLE=9, DIV=10, SRA=11, NOR=12)
  - an is_multi(code) function
- Sub-module alu_ctrl_decode: purely combinational ALUOp/Funct/EXT_OPS → {code, illegal}.
- alu_control_seq instantiates alu_ctrl_decode and adds the FSM, counter and handshake.

Test Plan:
- Reset then ALUOp=2, Funct=0x20, in_valid 1 cycle, out_ready=1 → next cycle out_valid=1, ALUControl=2, illegal=0, busy=0.
- ALUOp=2, Funct=0x02, MUL_CYCLES=3 → busy=1 for 2 cycles, out_valid rises 3 cycles after acceptance with ALUControl=3, in_ready=0 throughout BUSY.
- Back-to-back ALUOp 0, 1, 4 with out_ready=1 → out_valid continuous for 3 cycles, ALUControl 2, 6, 0. Repeat with out_ready=0 for 2 cycles on the first op → ALUControl=2 held, in_ready=0, no ops lost.
- ALUOp=2, Funct=0x1A: EXT_OPS=1 → ALUControl=10 after 8 cycles. EXT_OPS=0 → ALUControl=0 with illegal=1 after 1 cycle. Separately, ALUOp=13 → ALUControl=0, illegal=1.
- Mul accepted, flush asserted in the 2nd BUSY cycle alongside in_valid → next cycle state IDLE, out_valid=0, busy=0, and the concurrent input is not accepted.
- Rst pulled low mid-BUSY between clock edges → outputs 0 immediately (asynchronously). After release, an ALUOp=10 op yields ALUControl=8 at latency 1.
